dev_regs_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the 4-entry device register block. It serialises register read/write transactions from two masters onto the single device-side port (address, write_en, read_en, data_in, read_data). It generates one-cycle strobes, absorbs the device's one-cycle registered read latency and returns an ack/err/rdata response to the owning master. It also rejects addresses outside the implemented register range without touching the device.

---
 rtl/dev_regs_arbiter.sv | 142 ++++++++++++++
 tb/tb_dev_regs_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_regs_arbiter.sv
// Round-robin arbiter that serialises two masters' register transactions onto one device port.
// Out-of-range addresses are answered with ack+err without touching the device.
module dev_regs_arbiter #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int NUM_REGS = 4
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] dev_address,
  output logic          dev_write_en,
  output logic          dev_read_en,
  output logic [DW-1:0] dev_data_in,
  input  logic [DW-1:0] dev_read_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic [AW:0] NUM_REGS_W = (AW+1)'(NUM_REGS);

  state_t                 state_reg;
  logic                   gnt_idx_reg;
  logic                   last_gnt_reg;
  logic                   wr_reg;
  logic [1:0]             ack_reg;
  logic [1:0]             err_reg;
  logic [1:0][DW-1:0]     rdata_reg;
  logic [AW-1:0]          dev_address_reg;
  logic [DW-1:0]          dev_data_in_reg;
  logic                   dev_write_en_reg;
  logic                   dev_read_en_reg;

  logic [1:0]             req_vec;
  logic [1:0]             wr_vec;
  logic [1:0][AW-1:0]     addr_vec;
  logic [1:0][DW-1:0]     wdata_vec;

  logic                   gnt_valid;
  logic                   gnt_sel;
  logic                   sel_wr;
  logic                   sel_in_range;
  logic [AW-1:0]          sel_addr;
  logic [DW-1:0]          sel_wdata;

  assign req_vec   = {m1_req, m0_req};
  assign wr_vec    = {m1_wr, m0_wr};
  assign addr_vec  = {m1_addr, m0_addr};
  assign wdata_vec = {m1_wdata, m0_wdata};

  // On a tie the master that did not win last time is chosen.
  always_comb begin
    gnt_valid    = |req_vec;
    gnt_sel      = (&req_vec) ? ~last_gnt_reg : req_vec[1];
    sel_wr       = wr_vec[gnt_sel];
    sel_addr     = addr_vec[gnt_sel];
    sel_wdata    = wdata_vec[gnt_sel];
    sel_in_range = ({1'b0, sel_addr} < NUM_REGS_W);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_reg        <= IDLE;
      gnt_idx_reg      <= 1'b0;
      last_gnt_reg     <= 1'b1;
      wr_reg           <= 1'b0;
      ack_reg          <= '0;
      err_reg          <= '0;
      rdata_reg        <= '0;
      dev_address_reg  <= '0;
      dev_data_in_reg  <= '0;
      dev_write_en_reg <= 1'b0;
      dev_read_en_reg  <= 1'b0;
    end else begin
      ack_reg          <= '0;
      err_reg          <= '0;
      dev_write_en_reg <= 1'b0;
      dev_read_en_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (gnt_valid) begin
            gnt_idx_reg  <= gnt_sel;
            last_gnt_reg <= gnt_sel;
            wr_reg       <= sel_wr;
            if (sel_in_range) begin
              dev_address_reg  <= sel_addr;
              dev_data_in_reg  <= sel_wdata;
              dev_write_en_reg <= sel_wr;
              dev_read_en_reg  <= ~sel_wr;
              state_reg        <= ISSUE;
            end else begin
              // Error response: rdata cleared now so it is stable when ack appears.
              ack_reg[gnt_sel]   <= 1'b1;
              err_reg[gnt_sel]   <= 1'b1;
              rdata_reg[gnt_sel] <= '0;
              state_reg          <= RESP;
            end
          end
        end
        ISSUE: begin
          if (wr_reg) begin
            ack_reg[gnt_idx_reg] <= 1'b1;
            state_reg            <= RESP;
          end else begin
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          rdata_reg[gnt_idx_reg] <= dev_read_data;
          ack_reg[gnt_idx_reg]   <= 1'b1;
          state_reg              <= RESP;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m0_ack       = ack_reg[0];
  assign m0_err       = err_reg[0];
  assign m0_rdata     = rdata_reg[0];
  assign m1_ack       = ack_reg[1];
  assign m1_err       = err_reg[1];
  assign m1_rdata     = rdata_reg[1];
  assign dev_address  = dev_address_reg;
  assign dev_data_in  = dev_data_in_reg;
  assign dev_write_en = dev_write_en_reg;
  assign dev_read_en  = dev_read_en_reg;

endmodule

// File: tb/tb_dev_regs_arbiter.sv
// Randomised bench for dev_regs_arbiter: a transaction-level model predicts grant order,
// strobe/ack timing and returned data; a small register file stands in for the device.
module tb_dev_regs_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NUM_REGS = 4;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          m0_req = 1'b0, m0_wr = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_ack, m0_err;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_wr = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_ack, m1_err;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] dev_address;
  logic          dev_write_en, dev_read_en;
  logic [DW-1:0] dev_data_in;
  logic [DW-1:0] dev_read_data = '0;

  dev_regs_arbiter #(.AW(AW), .DW(DW), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .resetb(resetb),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dev_address(dev_address), .dev_write_en(dev_write_en), .dev_read_en(dev_read_en),
    .dev_data_in(dev_data_in), .dev_read_data(dev_read_data)
  );

  always #5 clk = ~clk;

  // Device: register file with one-cycle registered read.
  logic [DW-1:0] dev_mem [16] = '{default: '0};
  always @(posedge clk) begin
    if (dev_write_en) dev_mem[dev_address] <= dev_data_in;
    if (dev_read_en)  dev_read_data <= dev_mem[dev_address];
  end

  int test_cnt = 0;
  int fail_cnt = 0;

  // Reference model state
  int            k = 0;
  int            next_idle = 0;
  bit            last_gnt = 1'b1;
  int            p_strobe_cyc = -1, p_ack_cyc = -1;
  bit            p_m, p_wr, p_oob;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic [DW-1:0] mem_m [16] = '{default: '0};
  logic [DW-1:0] mrdata [2];
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  bit            exp_we, exp_re;
  logic [1:0]    exp_ack, exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    k = 0; next_idle = 0; last_gnt = 1'b1;
    p_strobe_cyc = -1; p_ack_cyc = -1;
    mrdata[0] = '0; mrdata[1] = '0;
    exp_addr = '0; exp_data = '0;
    exp_we = 0; exp_re = 0; exp_ack = '0; exp_err = '0;
  endtask

  // Decide the grant for the current cycle from the inputs being presented.
  task automatic model_grant();
    bit            sel, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (k >= next_idle && (m0_req || m1_req)) begin
      sel = (m0_req && m1_req) ? !last_gnt : m1_req;
      last_gnt = sel;
      w = sel ? m1_wr : m0_wr;
      a = sel ? m1_addr : m0_addr;
      d = sel ? m1_wdata : m0_wdata;
      p_m = sel; p_wr = w; p_addr = a; p_wdata = d;
      p_oob = (a >= NUM_REGS);
      if (p_oob) begin
        p_strobe_cyc = -1; p_ack_cyc = k + 1; p_rdata = '0; next_idle = k + 2;
      end else begin
        p_strobe_cyc = k + 1;
        p_ack_cyc = k + (w ? 2 : 3);
        next_idle = k + (w ? 3 : 4);
        if (w) mem_m[a] = d;
        else   p_rdata = mem_m[a];
      end
    end
  endtask

  task automatic model_expect();
    exp_we = 0; exp_re = 0; exp_ack = '0; exp_err = '0;
    if (k == p_strobe_cyc) begin
      exp_we = p_wr; exp_re = !p_wr; exp_addr = p_addr; exp_data = p_wdata;
    end
    if (k == p_ack_cyc) begin
      exp_ack[p_m] = 1'b1;
      exp_err[p_m] = p_oob;
      if (p_oob || !p_wr) mrdata[p_m] = p_rdata;
    end
  endtask

  task automatic check_outputs();
    check_eq("m0_ack", m0_ack, exp_ack[0]);
    check_eq("m0_err", m0_err, exp_err[0]);
    check_eq("m1_ack", m1_ack, exp_ack[1]);
    check_eq("m1_err", m1_err, exp_err[1]);
    check_eq("m0_rdata", m0_rdata, mrdata[0]);
    check_eq("m1_rdata", m1_rdata, mrdata[1]);
    check_eq("dev_write_en", dev_write_en, exp_we);
    check_eq("dev_read_en", dev_read_en, exp_re);
    check_eq("dev_address", dev_address, exp_addr);
    check_eq("dev_data_in", dev_data_in, exp_data);
  endtask

  task automatic step();
    model_grant();
    @(posedge clk);
    #1;
    k++;
    model_expect();
    check_outputs();
    if (m0_ack) $display("[TB] cyc %0d m0 ack err=%0b rdata=%02h", k, m0_err, m0_rdata);
    if (m1_ack) $display("[TB] cyc %0d m1 ack err=%0b rdata=%02h", k, m1_err, m1_rdata);
  endtask

  task automatic set_m(input int i, input bit r, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (i == 0) begin m0_req = r; m0_wr = w; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = r; m1_wr = w; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic run_until_ack(input int i);
    bit got = 0;
    for (int n = 0; n < 12 && !got; n++) begin
      step();
      if ((i == 0) ? m0_ack : m1_ack) begin
        got = 1;
        if (i == 0) m0_req = 1'b0; else m1_req = 1'b0;
      end
    end
    check_eq("ack_wait", got, 1);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  int order[6];
  int nacks;
  bit seen0, seen1;

  initial begin
    // Reset values
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    resetb = 1'b1;
    model_reset();
    idle(2);

    // m0 writes 0xA5 to register 2
    set_m(0, 1, 1, 4'd2, 8'hA5);
    run_until_ack(0);
    idle(2);

    // m1 reads register 2 back
    set_m(1, 1, 0, 4'd2, 8'h00);
    run_until_ack(1);
    check_eq("m1_read_a5", m1_rdata, 8'hA5);
    check_eq("m0_rdata_kept", m0_rdata, 8'h00);
    idle(2);

    // Simultaneous requests: m0 first, then m1
    set_m(0, 1, 1, 4'd1, 8'h3C);
    set_m(1, 1, 0, 4'd1, 8'h00);
    seen0 = 0; seen1 = 0;
    for (int n = 0; n < 20 && !(seen0 && seen1); n++) begin
      step();
      if (m0_ack) begin seen0 = 1; m0_req = 1'b0; end
      if (m1_ack) begin seen1 = 1; m1_req = 1'b0; check_eq("m0_first", seen0, 1); end
    end
    check_eq("both_acked", {seen0, seen1}, 2'b11);
    idle(2);

    // Both request continuously: grants alternate
    set_m(0, 1, 0, 4'd0, 8'h11);
    set_m(1, 1, 1, 4'd3, 8'h22);
    nacks = 0;
    for (int n = 0; n < 40 && nacks < 6; n++) begin
      step();
      if (m0_ack && nacks < 6) begin
        order[nacks] = 0; nacks++;
        set_m(0, 1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom));
      end
      if (m1_ack && nacks < 6) begin
        order[nacks] = 1; nacks++;
        set_m(1, 1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom));
      end
      if (nacks == 6) begin m0_req = 1'b0; m1_req = 1'b0; end
    end
    check_eq("six_acks", nacks, 6);
    for (int j = 0; j < 6; j++) check_eq("rr_order", order[j], j % 2);
    m0_req = 1'b0; m1_req = 1'b0;
    idle(2);

    // Out-of-range read by m0
    set_m(0, 1, 0, 4'd5, 8'h00);
    step();
    check_eq("oob_ack", m0_ack, 1);
    check_eq("oob_err", m0_err, 1);
    check_eq("oob_rdata", m0_rdata, 8'h00);
    m0_req = 1'b0;
    idle(2);

    // Reset during CAPTURE of a read, then a clean read
    set_m(0, 1, 1, 4'd1, 8'h5A);
    run_until_ack(0);
    idle(1);
    set_m(0, 1, 0, 4'd1, 8'h00);
    step();
    step();
    m0_req = 1'b0;
    #2 resetb = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    resetb = 1'b1;
    model_reset();
    idle(1);
    set_m(0, 1, 0, 4'd1, 8'h00);
    run_until_ack(0);
    check_eq("post_reset_read", m0_rdata, 8'h5A);
    idle(2);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if (m0_req && m0_ack) begin
        if ($urandom_range(0, 1) == 0) m0_req = 1'b0;
        else set_m(0, 1, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3)),
                   8'($urandom));
      end else if (!m0_req && $urandom_range(0, 2) == 0) begin
        set_m(0, 1, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3)),
              8'($urandom));
      end
      if (m1_req && m1_ack) begin
        if ($urandom_range(0, 1) == 0) m1_req = 1'b0;
        else set_m(1, 1, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3)),
                   8'($urandom));
      end else if (!m1_req && $urandom_range(0, 2) == 0) begin
        set_m(1, 1, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3)),
              8'($urandom));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
